reg_file_read_control: RTL
==========================

// Module: reg_file_read_control
// PURPOSE
//  Read-side counterpart of the register-file write controller in the PIC16C5x core.
//  Resolves the file operand (f = IR[4:0]) into an effective address:
//   - direct or indirect via INDF/FSR, with FSR bank bits applied;
//   - drives the synchronous GPR RAM, or selects a special register.
//  Forwards a coincident Q4 write and presents a registered operand to the ALU with a valid pulse.
//  One read transaction per instruction cycle, sequenced Q1..Q4.
// PARAMETERS
//  DATA_WIDTH   8   register/operand width
//  ADDR_WIDTH   7   effective file address width ({bank[1:0], f[4:0]})
// PORTS
//  clk            in   1    core clock; one edge per Q phase
//  rst_n          in   1    asynchronous active-low reset
//  cycleStart     in   1    one-clock pulse marking Q1 of an instruction needing a file read
//  fileAddrIn     in   5    IR[4:0], captured on cycleStart
//  fsrIn          in   8    current FSR
//  statusIn       in   8    current STATUS
//  tmr0In         in   8    current TMR0
//  pclIn          in   8    current PCL
//  portAIn        in   8    PORTA pin values
//  portBIn        in   8    PORTB pin values
//  portCIn        in   8    PORTC pin values
//  gprRdData      in   8    GPR RAM read data, valid 1 clk after gprRdEn
//  fwdWriteEn     in   1    GPR write in progress (Q4 write from write control)
//  fwdWriteAddr   in   7    effective address of that write
//  fwdWriteData   in   8    data of that write
//  gprRdEn        out  1    RAM read strobe
//  gprRdAddr      out  7    RAM read address
//  operandOut     out  8    registered file operand for the ALU
//  operandValid   out  1    one-clock pulse, operandOut updated this cycle
//  busy           out  1    high from the clock after cycleStart until back in IDLE
// BEHAVIOUR
//  Reset: state=IDLE; operandOut=0; operandValid=0; gprRdEn=0; gprRdAddr=0; busy=0.
//  FSM, one state per clock:
//   - IDLE --cycleStart--> DECODE -> READ -> CAPTURE -> DONE -> IDLE.
//   - cycleStart in any non-IDLE state is ignored; the transaction in flight completes.
//  DECODE: latch f=fileAddrIn; compute eff:
//   - raw = (f==0) ? fsrIn[4:0] : f;  bank = (f==0) ? fsrIn[6:5] : fsrIn[6:5];
//   - eff = raw[4] ? {bank, raw} : {2'b00, raw}; 00h-0Fh unbanked, 10h-1Fh banked.
//   - Indirect through INDF with FSR[4:0]==0 (INDF of INDF): eff = 0, reads 8'h00.
//  READ (combinational decode of eff[4:0]):
//   - 00h -> 00h; 01h -> tmr0In; 02h -> pclIn; 03h -> statusIn; 04h -> fsrIn;
//   - 05h/06h/07h -> portA/B/CIn;
//   - 08h-1Fh: gprRdEn=1 for this clock only, gprRdAddr=eff (gprRdAddr held until next read).
//   - Special-register value is sampled into a holding reg at the end of READ.
//  CAPTURE:
//   - GPR: operandOut <= gprRdData; special: operandOut <= holding reg.
//   - Forwarding: if fwdWriteEn && fwdWriteAddr==eff in READ or CAPTURE, use the latest fwdWriteData
//     (CAPTURE wins over READ). Forwarding applies to GPR addresses only.
//  DONE: operandValid=1 (exactly one clock), operandOut stable; busy drops next clock.
//  Latency: cycleStart at edge N -> operandValid high in cycle N+4; operandOut holds until next CAPTURE.
//  Mid-operation rst_n low: immediate return to reset values. No partial operandValid pulse.
//  Widths: address compare is full 7-bit; no arithmetic on data.
// TESTING
//  1 Direct GPR: f=0x0A, RAM[0x0A]=0x5C
//    -> gprRdEn one clk with gprRdAddr=0x0A; operandOut=0x5C; operandValid at N+4.
//  2 Banked: f=0x15, FSR=0x40 -> gprRdAddr=0x55; f=0x0C, FSR=0x60 -> gprRdAddr=0x0C (unbanked).
//  3 Indirect: f=0, FSR=0x3A, RAM[0x3A]=0xA7 -> gprRdAddr=0x3A, operandOut=0xA7.
//    f=0, FSR=0x00 -> operandOut=0x00, gprRdEn never asserted.
//  4 Special regs: f=3, STATUS=0x1C -> 0x1C; f=6, portB=0xF0 -> 0xF0; gprRdEn stays 0.
//  5 Forwarding: f=0x10, RAM=0x11, fwdWriteEn in CAPTURE, addr 0x10, data 0x99 -> operandOut=0x99.
//    Mismatched fwdWriteAddr -> 0x11.
//  6 cycleStart during busy ignored (one operandValid only).
//    rst_n low in READ -> all outputs 0 asynchronously; next cycleStart completes normally.

Source files
------------

// File: rtl/reg_file_read_control.sv
// reg_file_read_control: resolves f into an effective file address, reads GPR RAM or a special register, forwards Q4 writes, and presents a registered operand with a valid pulse
module reg_file_read_control #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cycleStart,
  input  logic [4:0]            i_fileAddrIn,
  input  logic [DATA_WIDTH-1:0] i_fsrIn,
  input  logic [DATA_WIDTH-1:0] i_statusIn,
  input  logic [DATA_WIDTH-1:0] i_tmr0In,
  input  logic [DATA_WIDTH-1:0] i_pclIn,
  input  logic [DATA_WIDTH-1:0] i_portAIn,
  input  logic [DATA_WIDTH-1:0] i_portBIn,
  input  logic [DATA_WIDTH-1:0] i_portCIn,
  input  logic [DATA_WIDTH-1:0] i_gprRdData,
  input  logic                  i_fwdWriteEn,
  input  logic [ADDR_WIDTH-1:0] i_fwdWriteAddr,
  input  logic [DATA_WIDTH-1:0] i_fwdWriteData,
  output logic                  o_gprRdEn,
  output logic [ADDR_WIDTH-1:0] o_gprRdAddr,
  output logic [DATA_WIDTH-1:0] o_operandOut,
  output logic                  o_operandValid,
  output logic                  o_busy
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  logic [2:0]            r_state;
  logic [4:0]            r_f;
  logic [ADDR_WIDTH-1:0] r_eff;
  logic                  r_gpr;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [4:0]            w_raw;
  logic [ADDR_WIDTH-1:0] w_eff;
  logic                  w_gpr;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_spec;
  // f==0 is INDF: the address comes from FSR; only 10h-1Fh see the bank bits
  assign w_raw  = (r_f == 5'd0) ? i_fsrIn[4:0] : r_f;
  assign w_eff  = w_raw[4] ? ADDR_WIDTH'({i_fsrIn[6:5], w_raw}) : ADDR_WIDTH'(w_raw);
  assign w_gpr  = w_eff[4] | w_eff[3];
  assign w_fwd  = i_fwdWriteEn && (i_fwdWriteAddr == r_eff) && r_gpr;
  assign o_busy = (r_state != S_IDLE);
  always_comb begin
    w_spec = '0;
    case (r_eff[2:0])
      3'd1:    w_spec = i_tmr0In;
      3'd2:    w_spec = i_pclIn;
      3'd3:    w_spec = i_statusIn;
      3'd4:    w_spec = i_fsrIn;
      3'd5:    w_spec = i_portAIn;
      3'd6:    w_spec = i_portBIn;
      3'd7:    w_spec = i_portCIn;
      default: w_spec = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_f            <= '0;
      r_eff          <= '0;
      r_gpr          <= 1'b0;
      r_hold         <= '0;
      r_fwd_hit      <= 1'b0;
      r_fwd_data     <= '0;
      o_gprRdEn      <= 1'b0;
      o_gprRdAddr    <= '0;
      o_operandOut   <= '0;
      o_operandValid <= 1'b0;
    end else begin
      o_gprRdEn      <= 1'b0;
      o_operandValid <= 1'b0;
      case (r_state)
        S_IDLE: if (i_cycleStart) begin
          r_f     <= i_fileAddrIn;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_eff     <= w_eff;
          r_gpr     <= w_gpr;
          r_fwd_hit <= 1'b0;
          o_gprRdEn <= w_gpr;
          if (w_gpr) o_gprRdAddr <= w_eff;
          r_state   <= S_READ;
        end
        S_READ: begin
          r_hold <= w_spec;
          if (w_fwd) begin
            r_fwd_hit  <= 1'b1;
            r_fwd_data <= i_fwdWriteData;
          end
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // a write seen now is newer than one seen in READ, which is newer than the RAM data
          o_operandOut   <= w_fwd ? i_fwdWriteData : r_fwd_hit ? r_fwd_data : r_gpr ? i_gprRdData : r_hold;
          o_operandValid <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
